// File: rtl/mem_arbiter.sv
// SRAM access sequencer: arbitrates load/store and instruction-fetch channels onto
// the memory interface, pacing READ/WRITE and framing writes with setup/hold cycles.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic [15:0] data_read,
    output logic [1:0]  control,
    output logic [15:0] addr,
    output logic [15:0] data_write,
    output logic [15:0] instr,
    output logic        if_done,
    output logic [15:0] rdata,
    output logic        mem_done,
    output logic        busy
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_IF     = 3'd2,
        S_WSETUP = 3'd3,
        S_WPULSE = 3'd4,
        S_WHOLD  = 3'd5
    } state_t;

    localparam logic [3:0] RD_LOAD   = 4'(READ_CYCLES - 1);
    localparam logic [3:0] WR_LOAD   = 4'(WRITE_CYCLES - 1);
    localparam logic [1:0] CTL_IDLE  = 2'b00;
    localparam logic [1:0] CTL_WRITE = 2'b01;
    localparam logic [1:0] CTL_READ  = 2'b10;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  control_q, control_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_write_q, data_write_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] rdata_q, rdata_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic        busy_q, busy_d;

    logic can_accept;
    logic accept_wr;
    logic accept_rd;
    logic accept_if;
    logic cnt_last;

    // Nothing is accepted while a done pulse is out: the requester has not yet
    // dropped the serviced request, and this also guarantees an IDLE gap.
    assign can_accept = (state_q == S_IDLE) && !if_done_q && !mem_done_q;
    assign accept_wr  = can_accept && mem_wr;
    assign accept_rd  = can_accept && mem_rd && !mem_wr;
    assign accept_if  = can_accept && if_req && !mem_wr && !mem_rd;
    assign cnt_last   = (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            control_q    <= CTL_IDLE;
            addr_q       <= 16'd0;
            data_write_q <= 16'd0;
            instr_q      <= 16'd0;
            rdata_q      <= 16'd0;
            if_done_q    <= 1'b0;
            mem_done_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            control_q    <= control_d;
            addr_q       <= addr_d;
            data_write_q <= data_write_d;
            instr_q      <= instr_d;
            rdata_q      <= rdata_d;
            if_done_q    <= if_done_d;
            mem_done_q   <= mem_done_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_wr) begin
                    state_d = S_WSETUP;
                end else if (accept_rd) begin
                    state_d = S_RD;
                    cnt_d   = RD_LOAD;
                end else if (accept_if) begin
                    state_d = S_IF;
                    cnt_d   = RD_LOAD;
                end
            end
            S_RD, S_IF: begin
                if (cnt_last) state_d = S_IDLE;
                else          cnt_d   = cnt_q - 4'd1;
            end
            S_WSETUP: begin
                state_d = S_WPULSE;
                cnt_d   = WR_LOAD;
            end
            S_WPULSE: begin
                if (cnt_last) state_d = S_WHOLD;
                else          cnt_d   = cnt_q - 4'd1;
            end
            S_WHOLD: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs: values computed here appear in the cycle after state_q.
    always_comb begin
        control_d    = control_q;
        addr_d       = addr_q;
        data_write_d = data_write_q;
        instr_d      = instr_q;
        rdata_d      = rdata_q;
        if_done_d    = 1'b0;
        mem_done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                control_d = CTL_IDLE;
                if (accept_wr) begin
                    addr_d       = mem_addr;
                    data_write_d = mem_wdata;
                end else if (accept_rd) begin
                    addr_d    = mem_addr;
                    control_d = CTL_READ;
                end else if (accept_if) begin
                    addr_d    = if_addr;
                    control_d = CTL_READ;
                end
            end
            S_RD: begin
                if (cnt_last) begin
                    rdata_d    = data_read;
                    mem_done_d = 1'b1;
                    control_d  = CTL_IDLE;
                end
            end
            S_IF: begin
                if (cnt_last) begin
                    instr_d   = data_read;
                    if_done_d = 1'b1;
                    control_d = CTL_IDLE;
                end
            end
            S_WSETUP: control_d = CTL_WRITE;
            S_WPULSE: begin
                if (cnt_last) begin
                    control_d  = CTL_IDLE;
                    mem_done_d = 1'b1;
                end
            end
            S_WHOLD: control_d = CTL_IDLE;
            default: control_d = CTL_IDLE;
        endcase
        busy_d = (state_d != S_IDLE) || if_done_d || mem_done_d;
    end

    assign control    = control_q;
    assign addr       = addr_q;
    assign data_write = data_write_q;
    assign instr      = instr_q;
    assign rdata      = rdata_q;
    assign if_done    = if_done_q;
    assign mem_done   = mem_done_q;
    assign busy       = busy_q;

endmodule
